// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand/result bus of the pipelined add/subtract unit.
//   Input side : in_valid, in_ready, a, b, cin, sub
//   Output side: out_valid, out_ready, sum, cout, overflow
//   master = operand source / result sink, slave = the adder itself.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry slices,
// one slice per register stage, with a valid/ready handshake on both sides.
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      pipelined_adder_if.slave (operands in, result out)
// WIDTH must be >= 1 and divisible by STAGES.
// Result: add -> {cout,sum} = a + b + cin ; sub -> {cout,sum} = a + ~b + ~cin.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_adder_if.slave  bus
);
  localparam int CHUNK = WIDTH / STAGES;

  // Stage k register holds: its valid bit, the (already inverted for sub)
  // operands still needed by later slices, the partial sum with slices
  // 0..k filled in, and the carry out of slice k.
  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic                         overflow_q, overflow_d;

  // Inputs seen by each stage's slice adder (stage 0 from the bus,
  // stage k from register k-1).
  logic [STAGES-1:0]            src_valid;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_b;
  logic [STAGES-1:0][WIDTH-1:0] src_sum;
  logic [STAGES-1:0]            src_carry;
  logic [STAGES-1:0][CHUNK-1:0] slice_sum;
  logic [STAGES-1:0]            slice_carry;

  logic en_s;
  logic unused_s;

  // The whole pipe advances together; it may move unless a result is
  // sitting at the output unaccepted.
  assign en_s = ~valid_q[STAGES-1] | bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract is a + ~b + ~cin, so fold the inversions in up front.
      assign src_valid[0] = bus.in_valid & en_s;
      assign src_a[0]     = bus.a;
      assign src_b[0]     = bus.sub ? ~bus.b : bus.b;
      assign src_sum[0]   = {WIDTH{1'b0}};
      assign src_carry[0] = bus.sub ? ~bus.cin : bus.cin;
    end else begin : g_next
      assign src_valid[k] = valid_q[k-1];
      assign src_a[k]     = a_q[k-1];
      assign src_b[k]     = b_q[k-1];
      assign src_sum[k]   = sum_q[k-1];
      assign src_carry[k] = carry_q[k-1];
    end

    assign {slice_carry[k], slice_sum[k]} =
        {1'b0, src_a[k][k*CHUNK +: CHUNK]} +
        {1'b0, src_b[k][k*CHUNK +: CHUNK]} +
        {{CHUNK{1'b0}}, src_carry[k]};
  end

  // Operand bits below the slice being summed are never read again; the
  // final stage keeps none at all.
  assign unused_s = ^{a_q, b_q};

  // Next-state for every stage: shift one step on en, otherwise hold.
  always_comb begin
    valid_d    = valid_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    if (en_s) begin
      valid_d = src_valid;
      a_d     = src_a;
      b_d     = src_b;
      carry_d = slice_carry;
      for (int k = 0; k < STAGES; k++) begin
        sum_d[k]                    = src_sum[k];
        sum_d[k][k*CHUNK +: CHUNK]  = slice_sum[k];
      end
      // Signed overflow: equal operand signs, result sign differs. The MSB
      // of the result comes out of the last slice.
      overflow_d = (src_a[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1]) &&
                   (slice_sum[STAGES-1][CHUNK-1] != src_a[STAGES-1][WIDTH-1]);
    end else begin
      valid_d    = valid_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      carry_d    = carry_q;
      overflow_d = overflow_q;
    end
  end

  // Pipeline registers, cleared asynchronously so in-flight beats vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= {STAGES{1'b0}};
      a_q        <= {(STAGES*WIDTH){1'b0}};
      b_q        <= {(STAGES*WIDTH){1'b0}};
      sum_q      <= {(STAGES*WIDTH){1'b0}};
      carry_q    <= {STAGES{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = en_s;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.sum       = sum_q[STAGES-1];
  assign bus.cout      = carry_q[STAGES-1];
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder in three shapes: W8/S2, W16/S4, W8/S1.
module tb_pipelined_adder;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  pipelined_adder_if #(.WIDTH(8))  bus8 ();
  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(8))  bus1 ();

  pipelined_adder #(.WIDTH(8),  .STAGES(2)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic, returns {overflow, cout, sum[15:0]}.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
    longint full, half, ua, ub, sa, sb, ci, r, sr;
    logic [63:0] rm;
    logic co, ov;
    full = 64'sd1 <<< w;
    half = full >>> 1;
    ua = {48'd0, a};
    ub = {48'd0, b};
    ci = cin ? 64'sd1 : 64'sd0;
    sa = (ua >= half) ? ua - full : ua;
    sb = (ub >= half) ? ub - full : ub;
    if (sub) begin
      r  = ua - ub - ci;
      co = (r >= 64'sd0);
      sr = sa - sb - ci;
    end else begin
      r  = ua + ub + ci;
      co = (r >= full);
      sr = sa + sb + ci;
    end
    ov = (sr >= half) || (sr < -half);
    rm = r & (full - 64'sd1);
    return {ov, co, rm[15:0]};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
      bus1.in_valid = 1'b0;  bus1.out_ready = 1'b1;
    end
  endtask

  task automatic test_reset;
    tests_run++;
    if ({bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow, bus8.in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_w8s2: got v=%b sum=%h c=%b o=%b rdy=%b, want v=0 sum=00 c=0 o=0 rdy=1",
               bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow, bus8.in_ready);
    end
    tests_run++;
    if ({bus16.out_valid, bus16.sum, bus1.out_valid, bus1.sum, bus16.in_ready, bus1.in_ready} !==
        {1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_others: got v16=%b s16=%h v1=%b s1=%h, want zeros and ready",
               bus16.out_valid, bus16.sum, bus1.out_valid, bus1.sum);
    end
  endtask

  // One beat through W8/S2: invalid after 1 cycle, result after 2.
  task automatic beat8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo, input string nm);
    @(negedge clk);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.sub = sub;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      bus8.in_valid = 1'b0;
      tests_run++;
      if (c < 2) begin
        if (bus8.out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_early: out_valid=%b at cycle %0d, want 0", nm, bus8.out_valid, c);
        end
      end else begin
        if ({bus8.out_valid, bus8.overflow, bus8.cout, bus8.sum} !== {1'b1, eo, ec, es}) begin
          tests_failed++;
          $display("FAIL %s: got v=%b o=%b c=%b sum=%h, want v=1 o=%b c=%b sum=%h",
                   nm, bus8.out_valid, bus8.overflow, bus8.cout, bus8.sum, eo, ec, es);
        end
      end
    end
    idle(1);
  endtask

  task automatic beat16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo, input string nm);
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus16.in_valid = 1'b0;
      tests_run++;
      if (c < 4) begin
        if (bus16.out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_early: out_valid=%b at cycle %0d, want 0", nm, bus16.out_valid, c);
        end
      end else begin
        if ({bus16.out_valid, bus16.overflow, bus16.cout, bus16.sum} !== {1'b1, eo, ec, es}) begin
          tests_failed++;
          $display("FAIL %s: got v=%b o=%b c=%b sum=%h, want v=1 o=%b c=%b sum=%h",
                   nm, bus16.out_valid, bus16.overflow, bus16.cout, bus16.sum, eo, ec, es);
        end
      end
    end
    idle(1);
  endtask

  task automatic beat1(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                       input logic [7:0] es, input logic ec, input logic eo, input string nm);
    @(negedge clk);
    bus1.a = a; bus1.b = b; bus1.cin = cin; bus1.sub = sub;
    bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    tests_run++;
    if ({bus1.out_valid, bus1.overflow, bus1.cout, bus1.sum} !== {1'b1, eo, ec, es}) begin
      tests_failed++;
      $display("FAIL %s: got v=%b o=%b c=%b sum=%h, want v=1 o=%b c=%b sum=%h",
               nm, bus1.out_valid, bus1.overflow, bus1.cout, bus1.sum, eo, ec, es);
    end
    idle(1);
  endtask

  task automatic test_arith;
    beat8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "w8_add_ff_01");
    beat8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "w8_add_7f_01");
    beat8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "w8_sub_05_07");
    beat8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "w8_sub_80_01");
    beat8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, "w8_add_ones_cin");
    beat8(8'h10, 8'h03, 1'b1, 1'b1, 8'h0C, 1'b1, 1'b0, "w8_sub_borrow_in");
    beat16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "w16_add_ffff_1");
    beat16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "w16_add_7fff_1");
    beat16(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "w16_sub_5_7");
    beat1(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "w8s1_add_ff_01");
    beat1(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "w8s1_add_7f_01");
    beat1(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, "w8s1_sub_05_07");
  endtask

  // a=i, b=7-i, cin=i[0]: sums alternate 7,8 on consecutive cycles.
  task automatic test_back_to_back;
    for (int c = 0; c < 8 + 4 + 2; c++) begin
      @(negedge clk);
      bus8.in_valid = (c < 8);  bus16.in_valid = (c < 8);  bus1.in_valid = (c < 8);
      bus8.out_ready = 1'b1;    bus16.out_ready = 1'b1;    bus1.out_ready = 1'b1;
      bus8.a  = 8'(c);  bus8.b  = 8'(7 - c);  bus8.cin  = c[0]; bus8.sub  = 1'b0;
      bus16.a = 16'(c); bus16.b = 16'(7 - c); bus16.cin = c[0]; bus16.sub = 1'b0;
      bus1.a  = 8'(c);  bus1.b  = 8'(7 - c);  bus1.cin  = c[0]; bus1.sub  = 1'b0;
      #1;
      if (c < 8) begin
        tests_run++;
        if ({bus8.in_ready, bus16.in_ready, bus1.in_ready} !== 3'b111) begin
          tests_failed++;
          $display("FAIL b2b_in_ready c=%0d: got %b%b%b, want 111", c, bus8.in_ready, bus16.in_ready, bus1.in_ready);
        end
      end
      tests_run++;
      if (bus8.out_valid !== ((c >= 2) && (c < 10)) ||
          (bus8.out_valid && bus8.sum !== 8'(7 + ((c - 2) & 1)))) begin
        tests_failed++;
        $display("FAIL b2b_w8s2 c=%0d: got v=%b sum=%0d", c, bus8.out_valid, bus8.sum);
      end
      tests_run++;
      if (bus16.out_valid !== ((c >= 4) && (c < 12)) ||
          (bus16.out_valid && bus16.sum !== 16'(7 + ((c - 4) & 1)))) begin
        tests_failed++;
        $display("FAIL b2b_w16s4 c=%0d: got v=%b sum=%0d", c, bus16.out_valid, bus16.sum);
      end
      tests_run++;
      if (bus1.out_valid !== ((c >= 1) && (c < 9)) ||
          (bus1.out_valid && bus1.sum !== 8'(7 + ((c - 1) & 1)))) begin
        tests_failed++;
        $display("FAIL b2b_w8s1 c=%0d: got v=%b sum=%0d", c, bus1.out_valid, bus1.sum);
      end
    end
    idle(1);
  endtask

  // Five beats a=16+i, b=i; output stalled for cycles 2..4 on the first result.
  task automatic test_backpressure;
    int beat = 0;
    int got  = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus8.in_valid  = (beat < 5);
      bus8.a = 8'(16 + beat); bus8.b = 8'(beat); bus8.cin = 1'b0; bus8.sub = 1'b0;
      bus8.out_ready = !((c >= 2) && (c <= 4));
      #1;
      if (c >= 2 && c <= 4) begin
        tests_run++;
        if ({bus8.in_ready, bus8.out_valid, bus8.sum} !== {1'b0, 1'b1, 8'd16}) begin
          tests_failed++;
          $display("FAIL bp_stall c=%0d: got rdy=%b v=%b sum=%0d, want rdy=0 v=1 sum=16",
                   c, bus8.in_ready, bus8.out_valid, bus8.sum);
        end
      end
      if (c == 5) begin
        tests_run++;
        if (bus8.in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL bp_resume_ready: got %b, want 1", bus8.in_ready);
        end
      end
      if (bus8.out_valid && bus8.out_ready) begin
        tests_run++;
        if (bus8.sum !== 8'(16 + 2 * got)) begin
          tests_failed++;
          $display("FAIL bp_order #%0d: got sum=%0d, want %0d", got, bus8.sum, 16 + 2 * got);
        end
        got++;
      end
      if (bus8.in_valid && bus8.in_ready) beat++;
    end
    tests_run++;
    if (got != 5 || beat != 5) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d results / %0d accepted, want 5 / 5", got, beat);
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      bus8.in_valid = 1'b1; bus8.out_ready = 1'b1; bus8.cin = 1'b0; bus8.sub = 1'b0;
      bus8.a = (c == 0) ? 8'h11 : 8'h01;
      bus8.b = (c == 0) ? 8'h22 : 8'h02;
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
    tests_run++;
    if ({bus8.out_valid, bus8.sum} !== {1'b1, 8'h33}) begin
      tests_failed++;
      $display("FAIL rstmid_pre: got v=%b sum=%h, want v=1 sum=33", bus8.out_valid, bus8.sum);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow} !== {1'b1 ^ 1'b1, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL rstmid_async: got v=%b sum=%h c=%b o=%b, want all 0",
               bus8.out_valid, bus8.sum, bus8.cout, bus8.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus8.out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_stale c=%0d: out_valid=%b, want 0", c, bus8.out_valid);
      end
    end
    beat8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, "rstmid_new");
  endtask

  task automatic test_random;
    logic [17:0] q[$];
    logic [17:0] r;
    logic [17:0] e;
    int acc = 0;
    int got = 0;
    int cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus8.in_valid  = (acc < 1000) && ($urandom_range(0, 3) != 0);
      bus8.a         = 8'($urandom_range(0, 255));
      bus8.b         = 8'($urandom_range(0, 255));
      bus8.cin       = 1'($urandom_range(0, 1));
      bus8.sub       = 1'($urandom_range(0, 1));
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus8.out_valid && bus8.out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("FAIL rand_spurious: result sum=%h with nothing outstanding", bus8.sum);
        end else begin
          e = q.pop_front();
          if ({bus8.overflow, bus8.cout, bus8.sum} !== {e[17], e[16], e[7:0]}) begin
            tests_failed++;
            $display("FAIL rand #%0d: got o=%b c=%b sum=%h, want o=%b c=%b sum=%h",
                     got, bus8.overflow, bus8.cout, bus8.sum, e[17], e[16], e[7:0]);
          end
        end
        got++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        r = ref_model(8, {8'h00, bus8.a}, {8'h00, bus8.b}, bus8.cin, bus8.sub);
        q.push_back(r);
        acc++;
      end
    end
    tests_run++;
    if (got != 1000 || q.size() != 0) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d results, %0d outstanding, want 1000 / 0", got, q.size());
    end
    idle(2);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus8.in_valid = 1'b0;  bus8.out_ready = 1'b1;  bus8.a = 8'h00;   bus8.b = 8'h00;   bus8.cin = 1'b0;  bus8.sub = 1'b0;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.a = 16'h0; bus16.b = 16'h0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus1.in_valid = 1'b0;  bus1.out_ready = 1'b1;  bus1.a = 8'h00;   bus1.b = 8'h00;   bus1.cin = 1'b0;  bus1.sub = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset;
    test_arith;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

endmodule
